// File: rtl/array_row_sequencer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// array_seq_pkg : opcode/state encodings and timer sizing for array_row_sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
package array_seq_pkg;

  typedef enum logic [1:0] {
    OP_WRITE   = 2'b00,
    OP_INFER   = 2'b01,
    OP_READOUT = 2'b10,
    OP_RSVD    = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_CLEAR = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Wide enough to hold the longer of the two phase lengths.
  function automatic int timer_width(input int pulse, input int settle);
    int m;
    m = (pulse > settle) ? pulse : settle;
    return $clog2(m + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/array_row_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// array_row_sequencer_if : command port and decoder-facing outputs
// Optional macro ARRAY_SEQ_ABORT_EN adds the abort input.   Rev 1.0
// ---------------------------------------------------------------------------
interface array_row_sequencer_if #(
  parameter int Narray = 2,
  parameter int Nword  = 3,
  parameter int N      = Nword + Narray
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [N-1:0] cmd_addr;
  logic         CWL;
  logic [N-1:0] adr_full_row;
  logic         inference;
  logic         read_out;
  logic         done;
  logic         cmd_err;
`ifdef ARRAY_SEQ_ABORT_EN
  logic         abort;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, abort,
    input  cmd_ready, CWL, adr_full_row, inference, read_out, done, cmd_err
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, abort,
    output cmd_ready, CWL, adr_full_row, inference, read_out, done, cmd_err
  );
`else
  modport master (
    output cmd_valid, cmd_op, cmd_addr,
    input  cmd_ready, CWL, adr_full_row, inference, read_out, done, cmd_err
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_addr,
    output cmd_ready, CWL, adr_full_row, inference, read_out, done, cmd_err
  );
`endif
endinterface
`default_nettype wire

// File: rtl/array_row_sequencer_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_phase_timer : loadable down-counter; expire flags the last phase cycle
// Rev 1.0
// ---------------------------------------------------------------------------
module seq_phase_timer #(
  parameter int W = 3
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         load,
  input  wire logic [W-1:0] load_val,
  output logic              expire
);
  localparam logic [W-1:0] C_ONE = W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (cnt_q != '0)
      cnt_d = cnt_q - C_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expire = (cnt_q == '0);
endmodule
`default_nettype wire

// File: rtl/array_row_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// array_row_sequencer : turns WRITE/INFER/READOUT commands into decoder timing
// Optional macro ARRAY_SEQ_ABORT_EN enables the abort input.   Rev 1.0
// ---------------------------------------------------------------------------
module array_row_sequencer
  import array_seq_pkg::*;
#(
  parameter int Narray        = 2,
  parameter int Nword         = 3,
  parameter int N             = Nword + Narray,
  parameter int PULSE_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  array_row_sequencer_if.slave bus
);
  localparam int               TW        = timer_width(PULSE_CYCLES, SETTLE_CYCLES);
  localparam logic [TW-1:0]    PULSE_LD  = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0]    SETTLE_LD = TW'(SETTLE_CYCLES - 1);
  localparam logic [Nword-1:0] ROW_ONE   = Nword'(1);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [N-1:0]     addr_q, addr_d;
  logic [Nword-1:0] row_q, row_d;
  logic             cwl_q, cwl_d;
  logic [N-1:0]     adr_q, adr_d;
  logic             inf_q, inf_d;
  logic             ro_q, ro_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             timer_load;
  logic [TW-1:0]    timer_val;
  logic             timer_expire;
  logic             abort_in;
  logic             abort_hit;
  logic             row_active;

`ifdef ARRAY_SEQ_ABORT_EN
  assign abort_in = bus.abort;
`else
  assign abort_in = 1'b0;
`endif

  seq_phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .expire   (timer_expire)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    row_d      = row_q;
    timer_load = 1'b0;
    timer_val  = '0;
    abort_hit  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          op_d       = op_e'(bus.cmd_op);
          addr_d     = bus.cmd_addr;
          row_d      = '0;
          timer_load = 1'b1;
          case (op_d)
            OP_WRITE, OP_INFER: begin
              state_d   = ST_SETUP;
              timer_val = SETTLE_LD;
            end
            OP_READOUT: begin
              state_d   = ST_CLEAR;
              timer_val = PULSE_LD;
            end
            default: state_d = ST_DONE;
          endcase
        end
      end
      ST_SETUP: begin
        if (timer_expire) begin
          state_d    = ST_PULSE;
          timer_load = 1'b1;
          timer_val  = PULSE_LD;
        end
      end
      ST_PULSE: begin
        if (timer_expire) begin
          state_d    = ST_HOLD;
          timer_load = 1'b1;
          timer_val  = SETTLE_LD;
        end
      end
      ST_HOLD: begin
        if (timer_expire) begin
          // The last row goes straight to DONE so the counter never wraps visibly.
          if (op_q == OP_INFER && row_q != '1) begin
            row_d      = row_q + ROW_ONE;
            state_d    = ST_SETUP;
            timer_load = 1'b1;
            timer_val  = SETTLE_LD;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_CLEAR: begin
        if (timer_expire) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (abort_in && (state_q inside {ST_SETUP, ST_PULSE, ST_HOLD, ST_CLEAR})) begin
      state_d    = ST_DONE;
      abort_hit  = 1'b1;
      timer_load = 1'b0;
    end

    // Outputs are registered, so they are decoded from the next state.
    row_active = (state_d inside {ST_SETUP, ST_PULSE, ST_HOLD});
    cwl_d      = (state_d == ST_PULSE);
    ro_d       = (state_d == ST_CLEAR);
    inf_d      = (op_d == OP_INFER) && (row_active || (state_d == ST_DONE && !abort_hit));
    done_d     = (state_d == ST_DONE);
    err_d      = done_d && (abort_hit || op_d == OP_RSVD);
    if (!row_active)
      adr_d = '0;
    else if (op_d == OP_INFER)
      adr_d = {{Narray{1'b0}}, row_d};
    else
      adr_d = addr_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_WRITE;
      addr_q  <= '0;
      row_q   <= '0;
      cwl_q   <= 1'b0;
      adr_q   <= '0;
      inf_q   <= 1'b0;
      ro_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      row_q   <= row_d;
      cwl_q   <= cwl_d;
      adr_q   <= adr_d;
      inf_q   <= inf_d;
      ro_q    <= ro_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.cmd_ready    = (state_q == ST_IDLE);
  assign bus.CWL          = cwl_q;
  assign bus.adr_full_row = adr_q;
  assign bus.inference    = inf_q;
  assign bus.read_out     = ro_q;
  assign bus.done         = done_q;
  assign bus.cmd_err      = err_q;
endmodule
`default_nettype wire

// File: tb/tb_array_row_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_array_row_sequencer : directed + randomized commands against a trace model
// Honours ARRAY_SEQ_ABORT_EN when defined.   Rev 1.0
// ---------------------------------------------------------------------------
module tb_array_row_sequencer;
  localparam int NA = 2;
  localparam int NW = 3;
  localparam int N  = NA + NW;
  localparam int P  = 4;
  localparam int S  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  array_row_sequencer_if #(.Narray(NA), .Nword(NW)) bus ();

  array_row_sequencer #(
    .Narray(NA), .Nword(NW), .PULSE_CYCLES(P), .SETTLE_CYCLES(S)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // One expected cycle of decoder-facing outputs.
  typedef struct packed {
    logic         cwl;
    logic         adr_chk;
    logic [N-1:0] adr;
    logic         inf;
    logic         ro;
    logic         done;
    logic         err;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add(input int n, input logic cwl, input logic adr_chk,
                     input logic [N-1:0] adr, input logic inf, input logic ro);
    exp_t e;
    e = '0;
    e.cwl = cwl; e.adr_chk = adr_chk; e.adr = adr; e.inf = inf; e.ro = ro;
    for (int k = 0; k < n; k++) q.push_back(e);
  endtask

  task automatic add_done(input logic inf, input logic err);
    exp_t e;
    e = '0;
    e.inf = inf; e.done = 1'b1; e.err = err;
    q.push_back(e);
  endtask

  // Expected per-cycle trace starting at the cycle after acceptance.
  task automatic build(input logic [1:0] op, input logic [N-1:0] addr);
    logic [N-1:0] r;
    q.delete();
    case (op)
      2'b00: begin
        add(S, 1'b0, 1'b1, addr, 1'b0, 1'b0);
        add(P, 1'b1, 1'b1, addr, 1'b0, 1'b0);
        add(S, 1'b0, 1'b1, addr, 1'b0, 1'b0);
        add_done(1'b0, 1'b0);
      end
      2'b01: begin
        for (int row = 0; row < (1 << NW); row++) begin
          r = N'(row);
          add(S, 1'b0, 1'b1, r, 1'b1, 1'b0);
          add(P, 1'b1, 1'b1, r, 1'b1, 1'b0);
          add(S, 1'b0, 1'b1, r, 1'b1, 1'b0);
        end
        add_done(1'b1, 1'b0);
      end
      2'b10: begin
        add(P, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        add_done(1'b0, 1'b0);
      end
      default: add_done(1'b0, 1'b1);
    endcase
  endtask

  // Entered and left at posedge+1; abort_at>0 raises abort in cycle T+abort_at.
  task automatic run_cmd(input logic [1:0] op, input logic [N-1:0] addr,
                         input logic noise, input int abort_at);
    exp_t e;
    chk("ready_before_accept", 32'(bus.cmd_ready), 32'd1);
    build(op, addr);
    if (abort_at > 0 && abort_at < q.size()) begin
      while (q.size() > abort_at) void'(q.pop_back());
      add_done(1'b0, 1'b1);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
`ifdef ARRAY_SEQ_ABORT_EN
    bus.abort = (abort_at > 0);
`endif
    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk); #1;
      if (noise && i != q.size() - 1) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'($urandom);
        bus.cmd_addr  = N'($urandom);
      end else begin
        bus.cmd_valid = 1'b0;
      end
`ifdef ARRAY_SEQ_ABORT_EN
      bus.abort = (abort_at > 0) && (i + 1 == abort_at);
`endif
      e = q[i];
      chk("cwl",       32'(bus.CWL),       32'(e.cwl));
      chk("inference", 32'(bus.inference), 32'(e.inf));
      chk("read_out",  32'(bus.read_out),  32'(e.ro));
      chk("done",      32'(bus.done),      32'(e.done));
      chk("cmd_err",   32'(bus.cmd_err),   32'(e.err));
      chk("ready_busy", 32'(bus.cmd_ready), 32'd0);
      if (e.adr_chk) chk("adr_full_row", 32'(bus.adr_full_row), 32'(e.adr));
    end
    @(posedge clk); #1;
`ifdef ARRAY_SEQ_ABORT_EN
    bus.abort = 1'b0;
`endif
    chk("ready_after_done", 32'(bus.cmd_ready), 32'd1);
    chk("done_one_cycle",   32'(bus.done),      32'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_cwl"},   32'(bus.CWL),          32'd0);
    chk({tag, "_adr"},   32'(bus.adr_full_row), 32'd0);
    chk({tag, "_inf"},   32'(bus.inference),    32'd0);
    chk({tag, "_ro"},    32'(bus.read_out),     32'd0);
    chk({tag, "_done"},  32'(bus.done),         32'd0);
    chk({tag, "_err"},   32'(bus.cmd_err),      32'd0);
    chk({tag, "_ready"}, 32'(bus.cmd_ready),    32'd1);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_addr  = '0;
`ifdef ARRAY_SEQ_ABORT_EN
    bus.abort     = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk_idle("in_reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_idle("after_reset");

    run_cmd(2'b00, 5'b10110, 1'b0, 0);
    run_cmd(2'b01, N'($urandom), 1'b0, 0);
    run_cmd(2'b10, '0, 1'b1, 0);
    run_cmd(2'b00, N'($urandom), 1'b1, 0);
    run_cmd(2'b11, N'($urandom), 1'b0, 0);

    // Asynchronous reset in the middle of a WRITE pulse.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b00;
    bus.cmd_addr  = 5'b01101;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("cwl_before_reset", 32'(bus.CWL), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("no_done_after_reset", 32'(bus.done), 32'd0);
    end
    run_cmd(2'b00, 5'b01101, 1'b0, 0);

    for (int n = 0; n < 12; n++)
      run_cmd(2'($urandom), N'($urandom), 1'($urandom), 0);

`ifdef ARRAY_SEQ_ABORT_EN
    run_cmd(2'b01, '0, 1'b0, 4);
    run_cmd(2'b10, '0, 1'b0, 2);
    run_cmd(2'b00, 5'b11111, 1'b0, 8);
    // Abort while idle must not start or end anything.
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    chk_idle("abort_idle");
    run_cmd(2'b00, 5'b00011, 1'b0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
